// File: rtl/clk_seq_pkg.sv
// Shared state encoding and counter-width helper for the clock-enable sequencer.
package clk_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    SETTLE    = 2'b01,
    RST_HOLD  = 2'b10,
    RUN       = 2'b11
  } state_t;

  localparam int unsigned LOST_W = 8;

  // Bits needed to count 0..n-1 (minimum 1).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_en_sequencer.sv
// Power-up reset sequencer and clock-enable strobe generator on the MMCM fast clock.
// Optional freeze/single-step of sys_en enabled by defining CLK_SEQ_STEP_EN.
module clk_en_sequencer
  import clk_seq_pkg::*;
#(
  parameter int unsigned SYS_DIV    = 4096,
  parameter int unsigned DIG_DIV    = 16,
  parameter int unsigned SETTLE_CYC = 1024,
  parameter int unsigned RST_TICKS  = 4
) (
  input  logic              clk,
  input  logic              greset_n,
  input  logic              locked,
  output logic              sys_rst,
  output logic              sys_en,
  output logic              digsel_en,
  output logic              running,
  output logic [1:0]        state,
  output logic [LOST_W-1:0] lock_lost_cnt
`ifdef CLK_SEQ_STEP_EN
  ,
  input  logic              freeze,
  input  logic              step
`endif
);

  localparam int unsigned SYS_W  = cnt_w(SYS_DIV);
  localparam int unsigned DIG_W  = cnt_w(DIG_DIV);
  localparam int unsigned SET_W  = cnt_w(SETTLE_CYC);
  localparam int unsigned TICK_W = cnt_w(RST_TICKS);

  state_t              state_q, state_nxt;
  logic [SET_W-1:0]    settle_cnt, settle_nxt;
  logic [SYS_W-1:0]    sys_cnt, sys_nxt;
  logic [TICK_W-1:0]   tick_cnt, tick_nxt;
  logic [DIG_W-1:0]    dig_cnt, dig_nxt;
  logic [LOST_W-1:0]   lost_nxt;
  logic                sys_en_nxt, digsel_nxt;
  logic                tick;
  logic                lk_s;
  logic                freeze_s;
  logic                step_rise;

  sync_2ff u_sync_lock (
    .clk   (clk),
    .rst_n (greset_n),
    .d     (locked),
    .q     (lk_s)
  );

`ifdef CLK_SEQ_STEP_EN
  logic step_s, step_d;

  sync_2ff u_sync_freeze (
    .clk   (clk),
    .rst_n (greset_n),
    .d     (freeze),
    .q     (freeze_s)
  );

  sync_2ff u_sync_step (
    .clk   (clk),
    .rst_n (greset_n),
    .d     (step),
    .q     (step_s)
  );

  always_ff @(posedge clk or negedge greset_n) begin
    if (!greset_n) step_d <= 1'b0;
    else           step_d <= step_s;
  end

  assign step_rise = step_s & ~step_d;
`else
  assign freeze_s  = 1'b0;
  assign step_rise = 1'b0;
`endif

  assign state = state_q;

  // Next state, counters and strobe decode; lock loss overrides any tick action.
  always_comb begin
    state_nxt  = state_q;
    settle_nxt = settle_cnt;
    sys_nxt    = sys_cnt;
    tick_nxt   = tick_cnt;
    dig_nxt    = dig_cnt;
    lost_nxt   = lock_lost_cnt;
    sys_en_nxt = 1'b0;
    digsel_nxt = 1'b0;
    tick       = (sys_cnt == SYS_W'(SYS_DIV - 1));

    case (state_q)
      WAIT_LOCK: begin
        settle_nxt = '0;
        sys_nxt    = '0;
        tick_nxt   = '0;
        dig_nxt    = '0;
        if (lk_s) state_nxt = SETTLE;
      end

      SETTLE: begin
        if (!lk_s) begin
          state_nxt  = WAIT_LOCK;
          settle_nxt = '0;
        end else if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
          state_nxt  = RST_HOLD;
          settle_nxt = '0;
          sys_nxt    = '0;
          tick_nxt   = '0;
        end else begin
          settle_nxt = settle_cnt + SET_W'(1);
        end
      end

      RST_HOLD, RUN: begin
        if (!lk_s) begin
          state_nxt = WAIT_LOCK;
          sys_nxt   = '0;
          tick_nxt  = '0;
          dig_nxt   = '0;
          if (lock_lost_cnt != '1) lost_nxt = lock_lost_cnt + LOST_W'(1);
        end else begin
          sys_nxt = tick ? '0 : sys_cnt + SYS_W'(1);
          if (state_q == RST_HOLD) begin
            sys_en_nxt = tick;
            if (tick) begin
              if (tick_cnt == TICK_W'(RST_TICKS - 1)) begin
                state_nxt = RUN;
                tick_nxt  = '0;
                dig_nxt   = '0;
              end else begin
                tick_nxt = tick_cnt + TICK_W'(1);
              end
            end
          end else begin
            // While frozen the internal tick only drives the display strobe.
            sys_en_nxt = freeze_s ? step_rise : tick;
            if (tick) begin
              digsel_nxt = (dig_cnt == DIG_W'(DIG_DIV - 1));
              dig_nxt    = digsel_nxt ? '0 : dig_cnt + DIG_W'(1);
            end
          end
        end
      end

      default: state_nxt = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge greset_n) begin
    if (!greset_n) begin
      state_q       <= WAIT_LOCK;
      settle_cnt    <= '0;
      sys_cnt       <= '0;
      tick_cnt      <= '0;
      dig_cnt       <= '0;
      lock_lost_cnt <= '0;
      sys_rst       <= 1'b1;
      sys_en        <= 1'b0;
      digsel_en     <= 1'b0;
      running       <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      settle_cnt    <= settle_nxt;
      sys_cnt       <= sys_nxt;
      tick_cnt      <= tick_nxt;
      dig_cnt       <= dig_nxt;
      lock_lost_cnt <= lost_nxt;
      sys_rst       <= (state_nxt != RUN);
      sys_en        <= sys_en_nxt;
      digsel_en     <= digsel_nxt;
      running       <= (state_nxt == RUN);
    end
  end

endmodule
